// File: rtl/freq_div_pkg.sv
// Shared constants for the programmable divider bank: default counter width,
// reset divisor and half-period divisors for common beep tones at 40 MHz.
package freq_div_pkg;

    localparam int FDIV_CNT_W   = 26;
    localparam int FDIV_DEF_DIV = 20_000;

    // Half-period divisors D for a 40 MHz Clk: f_out = 40e6 / (2 * (D + 1)).
    localparam int DIV_500HZ = 39_999;
    localparam int DIV_1KHZ  = 19_999;
    localparam int DIV_2KHZ  = 9_999;

endpackage

// File: rtl/freq_div_chan.sv
// One divider channel: counter, active/shadow divisor, square-wave and tick flops.
// Latency: outputs registered; toggle D+1 cycles after the counter restarts.
// Backpressure: none; shadow writes are accepted every cycle.
module freq_div_chan
    import freq_div_pkg::*;
#(
    parameter int               CNT_W   = FDIV_CNT_W,
    parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(FDIV_DEF_DIV)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             en,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    input  logic             sync,
    output logic             sq_out,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_q, act_d;
    logic [CNT_W-1:0] shd_q, shd_d;
    logic             sq_q, sq_d;
    logic             tick_q, tick_d;

    always_comb begin
        // A write landing on the terminal-count edge is already the next active divisor.
        shd_d  = wr ? wr_div : shd_q;
        cnt_d  = cnt_q;
        act_d  = act_q;
        sq_d   = sq_q;
        tick_d = 1'b0;
        if (!en || sync) begin
            cnt_d = '0;
            sq_d  = 1'b0;
            act_d = shd_d;
        end else if (cnt_q == act_q) begin
            cnt_d  = '0;
            sq_d   = ~sq_q;
            tick_d = 1'b1;
            act_d  = shd_d;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt_q  <= '0;
            act_q  <= DEF_DIV;
            shd_q  <= DEF_DIV;
            sq_q   <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            shd_q  <= shd_d;
            sq_q   <= sq_d;
            tick_q <= tick_d;
        end
    end

    assign sq_out = sq_q;
    assign tick   = tick_q;

endmodule

// File: rtl/freq_div_bank.sv
// N-channel programmable square-wave / tick generator with run-time divisor writes.
// Latency: wr_ack/wr_err 1 cycle after wr_en; ch_en registered, channel follows 1 cycle later.
// Backpressure: none; FDIV_SYNC_START_EN adds sync_go for an in-phase restart of all channels.
module freq_div_bank
    import freq_div_pkg::*;
#(
    parameter int                N_CH    = 4,
    parameter int                CNT_W   = FDIV_CNT_W,
    parameter logic [CNT_W-1:0]  DEF_DIV = CNT_W'(FDIV_DEF_DIV),
    parameter logic [N_CH-1:0]   RST_EN  = {N_CH{1'b1}},
    // One spare index bit so out-of-range channel numbers can be seen and rejected.
    localparam int               CH_W    = $clog2(N_CH) + 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [N_CH-1:0]  ch_en,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [CNT_W-1:0] wr_div,
    output logic             wr_ack,
    output logic             wr_err,
    output logic [N_CH-1:0]  sq_out,
    output logic [N_CH-1:0]  tick
`ifdef FDIV_SYNC_START_EN
    ,
    input  logic             sync_go
`endif
);

    localparam logic [CH_W-1:0] N_CH_L = CH_W'(N_CH);

    logic [N_CH-1:0] en_q, en_d;
    logic            wr_ack_q, wr_ack_d;
    logic            wr_err_q, wr_err_d;
    logic            wr_vld;
    logic            sync_all;

`ifdef FDIV_SYNC_START_EN
    assign sync_all = sync_go;
`else
    assign sync_all = 1'b0;
`endif

    assign wr_vld = wr_en && (wr_ch < N_CH_L);

    always_comb begin
        en_d     = ch_en;
        wr_ack_d = wr_vld;
        wr_err_d = wr_en && !wr_vld;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            en_q     <= RST_EN;
            wr_ack_q <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            en_q     <= en_d;
            wr_ack_q <= wr_ack_d;
            wr_err_q <= wr_err_d;
        end
    end

    assign wr_ack = wr_ack_q;
    assign wr_err = wr_err_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        freq_div_chan #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .Clk     (Clk),
            .Rst     (Rst),
            .en      (en_q[i]),
            .wr      (wr_vld && (wr_ch == CH_W'(i))),
            .wr_div  (wr_div),
            .sync    (sync_all),
            .sq_out  (sq_out[i]),
            .tick    (tick[i])
        );
    end

endmodule
